cmos_pingpong_wr: RTL and testbench

CMOS_PINGPONG_WR -- requirements
Module: cmos_pingpong_wr

---
 rtl/cmos_pingpong_wr.sv | 163 ++++++++++++++++
 tb/tb_cmos_pingpong_wr.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pingpong_wr.sv
// CMOS camera frame writer: captures pixels into a rotating set of frame banks
// and publishes each completed frame to the reader side.
module cmos_pingpong_wr #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned DROP_SHORT   = 1
) (
  input  logic                 cam_pclk,
  input  logic                 rst,
  input  logic                 cmos_frame_vsync,
  input  logic                 cmos_frame_href,
  input  logic                 cmos_frame_clken,
  input  logic [DATA_W-1:0]    cmos_frame_data,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  output logic [NUM_BANKS-1:0] ram_we,
  output logic [1:0]           wr_bank,
  output logic [1:0]           rd_bank,
  output logic                 rd_valid,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam int unsigned      CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_PIXELS);
  localparam logic [1:0]       LAST_BANK = 2'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    OVERFLOW = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_vsync_d;
  logic [CNT_W-1:0]     r_pix_cnt;
  logic [ADDR_W-1:0]    r_ram_addr;
  logic [DATA_W-1:0]    r_ram_wdata;
  logic [NUM_BANKS-1:0] r_ram_we;
  logic [1:0]           r_wr_bank;
  logic [1:0]           r_rd_bank;
  logic                 r_rd_valid;
  logic                 r_frame_done;
  logic                 r_frame_err;

  logic                 w_rise;
  logic                 w_fall;
  logic                 w_pix;
  logic                 w_clr;
  logic                 w_wr;
  logic                 w_publish;
  logic                 w_err;
  logic [1:0]           w_bank_nxt;

  assign w_rise     = cmos_frame_vsync & ~r_vsync_d;
  assign w_fall     = ~cmos_frame_vsync & r_vsync_d;
  assign w_pix      = cmos_frame_vsync & cmos_frame_href & cmos_frame_clken;
  assign w_bank_nxt = (r_wr_bank == LAST_BANK) ? 2'd0 : r_wr_bank + 2'd1;

  // State register; vsync_d resets high so a frame running at release is skipped
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_vsync_d <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_d <= cmos_frame_vsync;
    end
  end

  // Next state and per-cycle actions
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_wr        = 1'b0;
    w_publish   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = CAPTURE;
          w_clr       = 1'b1;
        end
      end
      CAPTURE: begin
        if (w_rise) begin
          w_state_nxt = CAPTURE;
          w_clr       = 1'b1;
        end else if (w_fall) begin
          w_state_nxt = IDLE;
          if (r_pix_cnt == FULL_CNT) begin
            w_publish = 1'b1;
          end else begin
            w_err     = 1'b1;
            w_publish = (DROP_SHORT == 0);
          end
        end else if (w_pix) begin
          if (r_pix_cnt == FULL_CNT) begin
            w_state_nxt = OVERFLOW;
          end else begin
            w_wr = 1'b1;
          end
        end
      end
      OVERFLOW: begin
        if (w_rise) begin
          w_state_nxt = CAPTURE;
          w_clr       = 1'b1;
        end else if (w_fall) begin
          w_state_nxt = IDLE;
          w_err       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write port, pixel counter and bank bookkeeping
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      r_pix_cnt    <= '0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_we     <= '0;
      r_wr_bank    <= 2'd0;
      r_rd_bank    <= 2'd0;
      r_rd_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= w_publish;
      r_frame_err  <= w_err;
      r_ram_we     <= w_wr ? (NUM_BANKS'(1) << r_wr_bank) : '0;
      if (w_clr) begin
        r_pix_cnt <= '0;
      end else if (w_wr) begin
        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
      end
      if (w_wr) begin
        r_ram_addr  <= r_pix_cnt[ADDR_W-1:0];
        r_ram_wdata <= cmos_frame_data;
      end
      if (w_publish) begin
        r_rd_bank  <= r_wr_bank;
        r_rd_valid <= 1'b1;
        r_wr_bank  <= w_bank_nxt;
      end
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign ram_we     = r_ram_we;
  assign wr_bank    = r_wr_bank;
  assign rd_bank    = r_rd_bank;
  assign rd_valid   = r_rd_valid;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_cmos_pingpong_wr.sv
// Bench for cmos_pingpong_wr: three instances (2 banks drop-short, 3 banks,
// 2 banks publish-short) share one camera stream and a frame-level model.
module tb_cmos_pingpong_wr;

  localparam int FP = 8;
  localparam int NB [3] = '{2, 3, 2};
  localparam int DS [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs  = 1'b0;
  logic        hr  = 1'b0;
  logic        ce  = 1'b0;
  logic [15:0] dat = 16'd0;

  logic [3:0]  addr_o [3];
  logic [15:0] wd_o   [3];
  logic [3:0]  we_o   [3];
  logic [1:0]  wb_o   [3];
  logic [1:0]  rb_o   [3];
  logic        rv_o   [3];
  logic        fd_o   [3];
  logic        fe_o   [3];
  logic [1:0]  we_a;
  logic [2:0]  we_b;
  logic [1:0]  we_c;

  assign we_o[0] = {2'b00, we_a};
  assign we_o[1] = {1'b0, we_b};
  assign we_o[2] = {2'b00, we_c};

  always #5 clk = ~clk;

  cmos_pingpong_wr #(.DATA_W(16), .ADDR_W(4), .FRAME_PIXELS(FP), .NUM_BANKS(2), .DROP_SHORT(1)) dut_a (
    .cam_pclk(clk), .rst(rst), .cmos_frame_vsync(vs), .cmos_frame_href(hr),
    .cmos_frame_clken(ce), .cmos_frame_data(dat), .ram_addr(addr_o[0]), .ram_wdata(wd_o[0]),
    .ram_we(we_a), .wr_bank(wb_o[0]), .rd_bank(rb_o[0]), .rd_valid(rv_o[0]),
    .frame_done(fd_o[0]), .frame_err(fe_o[0]));

  cmos_pingpong_wr #(.DATA_W(16), .ADDR_W(4), .FRAME_PIXELS(FP), .NUM_BANKS(3), .DROP_SHORT(1)) dut_b (
    .cam_pclk(clk), .rst(rst), .cmos_frame_vsync(vs), .cmos_frame_href(hr),
    .cmos_frame_clken(ce), .cmos_frame_data(dat), .ram_addr(addr_o[1]), .ram_wdata(wd_o[1]),
    .ram_we(we_b), .wr_bank(wb_o[1]), .rd_bank(rb_o[1]), .rd_valid(rv_o[1]),
    .frame_done(fd_o[1]), .frame_err(fe_o[1]));

  cmos_pingpong_wr #(.DATA_W(16), .ADDR_W(4), .FRAME_PIXELS(FP), .NUM_BANKS(2), .DROP_SHORT(0)) dut_c (
    .cam_pclk(clk), .rst(rst), .cmos_frame_vsync(vs), .cmos_frame_href(hr),
    .cmos_frame_clken(ce), .cmos_frame_data(dat), .ram_addr(addr_o[2]), .ram_wdata(wd_o[2]),
    .ram_we(we_c), .wr_bank(wb_o[2]), .rd_bank(rb_o[2]), .rd_valid(rv_o[2]),
    .frame_done(fd_o[2]), .frame_err(fe_o[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor log: {bank, addr, data} per observed write, plus pulse counters
  logic [31:0] got_mem  [3][1024];
  int          got_n    [3] = '{0, 0, 0};
  int          done_cnt [3] = '{0, 0, 0};
  int          err_cnt  [3] = '{0, 0, 0};

  int          rd_ptr    [3];
  int          snap_done [3];
  int          snap_err  [3];
  int          m_wr      [3];
  int          m_rd      [3];
  int          m_rv      [3];
  logic [15:0] pix_q [$];

  function automatic logic [3:0] oh2idx(input logic [3:0] v);
    case (v)
      4'b0001: return 4'd0;
      4'b0010: return 4'd1;
      4'b0100: return 4'd2;
      4'b1000: return 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (we_o[d] != 4'd0) begin
        if (got_n[d] < 1024) got_mem[d][got_n[d]] <= {oh2idx(we_o[d]), 12'(addr_o[d]), wd_o[d]};
        got_n[d] <= got_n[d] + 1;
      end
      if (fd_o[d]) done_cnt[d] <= done_cnt[d] + 1;
      if (fe_o[d]) err_cnt[d] <= err_cnt[d] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_model_reset();
    for (int d = 0; d < 3; d++) begin
      m_wr[d] = 0; m_rd[d] = 0; m_rv[d] = 0;
      rd_ptr[d] = got_n[d];
      snap_done[d] = done_cnt[d];
      snap_err[d] = err_cnt[d];
    end
  endtask

  task automatic snapshot();
    for (int d = 0; d < 3; d++) begin
      snap_done[d] = done_cnt[d];
      snap_err[d]  = err_cnt[d];
    end
  endtask

  task automatic send_pixels(input int n);
    logic [15:0] v;
    pix_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        case ($urandom_range(0, 2))
          0: begin hr = 1'b0; ce = 1'b0; end
          1: begin hr = 1'b1; ce = 1'b0; end
          default: begin hr = 1'b0; ce = 1'b1; end
        endcase
        dat = 16'($urandom);
        tick();
      end
      v = 16'($urandom);
      hr = 1'b1; ce = 1'b1; dat = v;
      pix_q.push_back(v);
      tick();
    end
    hr = 1'b0; ce = 1'b0;
  endtask

  task automatic check_pulses_none(input string nm);
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (done_cnt[d] - snap_done[d] != 0 || err_cnt[d] - snap_err[d] != 0) begin
        n_fail++;
        $display("FAIL %s dut%0d pulses done=%0d err=%0d expected 0/0", nm, d,
                 done_cnt[d] - snap_done[d], err_cnt[d] - snap_err[d]);
      end
    end
  endtask

  task automatic check_frame(input int n, input string nm);
    int nw, avail, exp_done, exp_err;
    logic [31:0] exp_w;
    for (int d = 0; d < 3; d++) begin
      nw = (n < FP) ? n : FP;
      avail = got_n[d] - rd_ptr[d];
      exp_done = ((n == FP) || (n < FP && DS[d] == 0)) ? 1 : 0;
      exp_err = (n != FP) ? 1 : 0;
      n_tests++;
      if (avail != nw) begin
        n_fail++;
        $display("FAIL %s dut%0d write count got %0d expected %0d", nm, d, avail, nw);
      end
      for (int i = 0; i < nw && i < avail; i++) begin
        exp_w = {4'(m_wr[d]), 12'(i), pix_q[i]};
        n_tests++;
        if (got_mem[d][rd_ptr[d] + i] !== exp_w) begin
          n_fail++;
          $display("FAIL %s dut%0d write %0d got %h expected %h", nm, d, i,
                   got_mem[d][rd_ptr[d] + i], exp_w);
        end
      end
      rd_ptr[d] = got_n[d];
      if (nw > 0) begin
        n_tests++;
        if (addr_o[d] !== 4'(nw - 1) || wd_o[d] !== pix_q[nw - 1] || we_o[d] !== 4'd0) begin
          n_fail++;
          $display("FAIL %s dut%0d hold addr=%0d data=%h we=%b expected %0d %h 0", nm, d,
                   addr_o[d], wd_o[d], we_o[d], nw - 1, pix_q[nw - 1]);
        end
      end
      n_tests++;
      if (done_cnt[d] - snap_done[d] != exp_done || err_cnt[d] - snap_err[d] != exp_err) begin
        n_fail++;
        $display("FAIL %s dut%0d pulses done=%0d err=%0d expected %0d/%0d", nm, d,
                 done_cnt[d] - snap_done[d], err_cnt[d] - snap_err[d], exp_done, exp_err);
      end
      if (exp_done == 1) begin
        m_rd[d] = m_wr[d];
        m_rv[d] = 1;
        m_wr[d] = (m_wr[d] + 1) % NB[d];
      end
      n_tests++;
      if (wb_o[d] !== 2'(m_wr[d]) || rb_o[d] !== 2'(m_rd[d]) || rv_o[d] !== 1'(m_rv[d])) begin
        n_fail++;
        $display("FAIL %s dut%0d banks wr=%0d rd=%0d valid=%0d expected %0d %0d %0d", nm, d,
                 wb_o[d], rb_o[d], rv_o[d], m_wr[d], m_rd[d], m_rv[d]);
      end
    end
  endtask

  task automatic run_frame(input int n, input string nm);
    snapshot();
    vs = 1'b1;
    tick();
    send_pixels(n);
    tick();
    vs = 1'b0;
    if ($urandom_range(0, 1) == 1) begin hr = 1'b1; ce = 1'b1; dat = 16'($urandom); end
    tick();
    hr = 1'b0; ce = 1'b0;
    tick();
    tick();
    check_frame(n, nm);
  endtask

  task automatic check_outputs_zero(input string nm);
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({addr_o[d], wd_o[d], we_o[d], wb_o[d], rb_o[d], rv_o[d], fd_o[d], fe_o[d]} !== 31'd0) begin
        n_fail++;
        $display("FAIL %s dut%0d outputs addr=%0d data=%h we=%b wr=%0d rd=%0d v=%0d d=%0d e=%0d expected all 0",
                 nm, d, addr_o[d], wd_o[d], we_o[d], wb_o[d], rb_o[d], rv_o[d], fd_o[d], fe_o[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hr = 1'($urandom); ce = 1'($urandom); dat = 16'($urandom);
      tick();
    end
    check_outputs_zero("reset");
    hr = 1'b0; ce = 1'b0;
    rst = 1'b0;
    tick();
    sync_model_reset();
  endtask

  task automatic test_single_frame();
    run_frame(FP, "single_frame");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) run_frame(FP, "rotation");
  endtask

  task automatic test_short_frame();
    run_frame(5, "short_frame");
  endtask

  task automatic test_overflow();
    run_frame(10, "overflow");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 12; f++) run_frame($urandom_range(1, 12), "random_frame");
  endtask

  task automatic test_vsync_at_release();
    rst = 1'b1; vs = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    sync_model_reset();
    send_pixels(4);
    tick();
    vs = 1'b0;
    tick(); tick(); tick();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (got_n[d] != rd_ptr[d]) begin
        n_fail++;
        $display("FAIL vsync_at_release dut%0d writes got %0d expected 0", d, got_n[d] - rd_ptr[d]);
      end
    end
    check_pulses_none("vsync_at_release");
    run_frame(FP, "after_release");
  endtask

  task automatic test_mid_frame_reset();
    snapshot();
    vs = 1'b1;
    tick();
    send_pixels(3);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (got_n[d] - rd_ptr[d] != 3) begin
        n_fail++;
        $display("FAIL mid_reset dut%0d writes got %0d expected 3", d, got_n[d] - rd_ptr[d]);
      end
    end
    vs = 1'b0;
    tick(); tick();
    check_pulses_none("mid_reset");
    rst = 1'b0;
    tick();
    sync_model_reset();
    run_frame(FP, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_frame();
    test_overflow();
    test_random_frames();
    test_vsync_at_release();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
